// File: rtl/instr_issue_unit.sv
// instr_issue_unit
//   Fetches instruction words from imem and issues them one per accepted ack.
//   After reset the word at RESET_ADDR is read as the start pc. LDM takes a
//   second fetch beat that is presented on imm. RET/RTI are followed by
//   FLUSH_CYCLES cycles with no fetch. A redirect reloads pc and discards
//   any ack arriving for the old fetch stream.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   imem_req/addr       fetch request (held until imem_ack) and its address
//   imem_ack/rdata      fetch completion and fetched word
//   stall               hazard hold
//   redirect_valid/pc   taken branch/call/return target
//   opcode/instr/imm    issued opcode, word and LDM immediate (registered)
//   imm_valid           second LDM beat on imm
//   issue_valid         real instruction issued this cycle
//   nop_signal          bubble indicator, always ~issue_valid
//   pc_out              address of the issued word
//
// state  | meaning
// VEC    | fetching the reset vector at RESET_ADDR
// FETCH  | fetching/issuing instruction words at pc
// IMM    | fetching the immediate word of an LDM
// FLUSH  | bubble countdown after RET/RTI, no fetch
module instr_issue_unit #(
    parameter logic [15:0] RESET_ADDR   = 16'h0000,
    parameter logic [4:0]  OP_LDM       = 5'b01100,
    parameter logic [4:0]  OP_RET       = 5'b10101,
    parameter logic [4:0]  OP_RTI       = 5'b10110,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [4:0]  opcode,
    output logic [15:0] instr,
    output logic [15:0] imm,
    output logic        imm_valid,
    output logic        issue_valid,
    output logic        nop_signal,
    output logic [15:0] pc_out
);

    typedef enum logic [1:0] {
        S_VEC   = 2'd0,
        S_FETCH = 2'd1,
        S_IMM   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_pending;
    logic        r_discard;
    logic [15:0] r_req_addr;

    logic [4:0]  r_opcode, w_opcode_nxt;
    logic [15:0] r_instr, w_instr_nxt;
    logic [15:0] r_imm, w_imm_nxt;
    logic [15:0] r_pc_out, w_pc_out_nxt;
    logic        r_issue_valid, w_issue_nxt;
    logic        r_imm_valid, w_immv_nxt;

    logic        w_req;
    logic        w_ack;
    logic        w_redir;
    logic        w_take;

    // A request that went out without an ack stays up regardless of stall.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            S_VEC:          w_req = 1'b1;
            S_FETCH, S_IMM: w_req = ~stall | r_pending;
            default:        w_req = r_pending;
        endcase
    end

    assign imem_req  = rst_n & w_req;
    assign imem_addr = r_pending ? r_req_addr :
                       (r_state == S_VEC) ? RESET_ADDR : r_pc;

    assign w_ack   = imem_ack & w_req;
    assign w_redir = redirect_valid & (r_state != S_VEC);
    // An ack is used only if no redirect is taken now and it does not
    // belong to a request issued before an earlier redirect.
    assign w_take  = w_ack & ~r_discard & ~w_redir;

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_cnt_nxt    = r_cnt;
        w_opcode_nxt = r_opcode;
        w_instr_nxt  = r_instr;
        w_imm_nxt    = r_imm;
        w_pc_out_nxt = r_pc_out;
        w_issue_nxt  = 1'b0;
        w_immv_nxt   = 1'b0;

        if (r_state == S_VEC) begin
            if (w_ack) begin
                w_pc_nxt    = imem_rdata;
                w_state_nxt = S_FETCH;
            end
        end else if (w_redir) begin
            w_pc_nxt    = redirect_pc;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_take) begin
                        w_instr_nxt  = imem_rdata;
                        w_opcode_nxt = imem_rdata[15:11];
                        w_pc_out_nxt = r_pc;
                        w_issue_nxt  = 1'b1;
                        w_pc_nxt     = r_pc + 16'd1;
                        if (imem_rdata[15:11] == OP_LDM) begin
                            w_state_nxt = S_IMM;
                        end else if (imem_rdata[15:11] == OP_RET ||
                                     imem_rdata[15:11] == OP_RTI) begin
                            w_state_nxt = S_FLUSH;
                            w_cnt_nxt   = FLUSH_CNT;
                        end
                    end
                end
                S_IMM: begin
                    if (w_take) begin
                        w_imm_nxt    = imem_rdata;
                        w_immv_nxt   = 1'b1;
                        w_issue_nxt  = 1'b1;
                        w_pc_out_nxt = r_pc;
                        w_pc_nxt     = r_pc + 16'd1;
                        w_state_nxt  = S_FETCH;
                    end
                end
                S_FLUSH: begin
                    // Countdown ignores stall; a zero count cannot trap us here.
                    if (r_cnt <= 3'd1) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                default: w_state_nxt = S_VEC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_VEC;
            r_pc          <= RESET_ADDR;
            r_cnt         <= 3'd0;
            r_pending     <= 1'b0;
            r_discard     <= 1'b0;
            r_req_addr    <= RESET_ADDR;
            r_opcode      <= 5'd0;
            r_instr       <= 16'd0;
            r_imm         <= 16'd0;
            r_pc_out      <= 16'd0;
            r_issue_valid <= 1'b0;
            r_imm_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pending     <= w_req & ~imem_ack;
            r_req_addr    <= imem_addr;
            if (w_ack) begin
                r_discard <= 1'b0;
            end else if (w_redir && w_req) begin
                r_discard <= 1'b1;
            end
            r_opcode      <= w_opcode_nxt;
            r_instr       <= w_instr_nxt;
            r_imm         <= w_imm_nxt;
            r_pc_out      <= w_pc_out_nxt;
            r_issue_valid <= w_issue_nxt;
            r_imm_valid   <= w_immv_nxt;
        end
    end

    assign opcode      = r_opcode;
    assign instr       = r_instr;
    assign imm         = r_imm;
    assign imm_valid   = r_imm_valid;
    assign issue_valid = r_issue_valid;
    assign nop_signal  = ~r_issue_valid;
    assign pc_out      = r_pc_out;

endmodule
